rgmii_nibble_tx: RTL and testbench

- Transmit-side counterpart of the RGMII nibble capture path.
- Accepts frame payload bytes on a valid/ready byte stream and drives an SDR nibble bus: one nibble per clk rising edge, tx_en high for the whole frame.
- Generates preamble, SFD, minimum-length padding, Ethernet FCS (CRC-32) and the inter-frame gap.
- Feeds the board RGMII TX pins; clk is forwarded to the PHY as the TX clock outside this block.

---
 rtl/rgmii_pkg.sv | 8 +
 rtl/eth_crc32_nib.sv | 14 +
 rtl/rgmii_nibble_tx.sv | 131 +++++++++++++
 tb/tb_rgmii_nibble_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_pkg.sv
// rgmii_pkg: RGMII TX state encoding, nibble constants and CRC-32 parameters shared with the receive path
package rgmii_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DRAIN} tx_state_e;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;
endpackage

// File: rtl/eth_crc32_nib.sv
// eth_crc32_nib: one-nibble step of the reflected Ethernet CRC-32 (LSB of the nibble first)
module eth_crc32_nib
  import rgmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 4; i++)
      crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ nib[i]) ? CRC32_POLY : 32'h0);
  end
endmodule

// File: rtl/rgmii_nibble_tx.sv
// rgmii_nibble_tx: byte stream to SDR RGMII nibble bus with preamble, SFD, padding, FCS and IFG
module rgmii_nibble_tx
  import rgmii_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int IFG_BYTES = 12,
  parameter int MIN_PAYLOAD = 60,
  parameter int APPEND_FCS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_en,
  output logic [3:0] tx_d,
  output logic       underrun,
  output logic       busy
);
  localparam logic [5:0] PRE_END = 6'(2 * PREAMBLE_BYTES - 1);
  localparam logic [5:0] IFG_END = 6'(2 * IFG_BYTES - 1);
  localparam tx_state_e TAIL = (APPEND_FCS != 0) ? S_FCS : S_IFG;
  tx_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic hi_q, hi_d, last_q, last_d;
  logic [7:0] byte_q, byte_d;
  logic [10:0] bc_q, bc_d, bc_inc;
  logic [31:0] crc_q, crc_d, crc_nib, crc_x;
  logic s_ready_q, s_ready_d, tx_en_q, tx_en_d, underrun_q, underrun_d, busy_q, busy_d;
  logic [3:0] tx_d_q, tx_d_d;
  eth_crc32_nib u_crc (.crc_in(crc_q), .nib(tx_d_q), .crc_out(crc_nib));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 6'd1;
    hi_d = hi_q;
    last_d = last_q;
    byte_d = byte_q;
    bc_d = bc_q;
    crc_d = crc_q;
    underrun_d = 1'b0;
    bc_inc = &bc_q ? bc_q : bc_q + 11'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        hi_d = 1'b0;
        if (s_valid && s_ready_q) begin
          byte_d = s_data;
          last_d = s_last;
          bc_d = '0;
          crc_d = CRC32_INIT;
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: if (cnt_q == PRE_END) begin
        state_d = S_SFD;
        cnt_d = '0;
      end
      S_SFD: if (cnt_q[0]) state_d = S_DATA;
      S_DATA, S_PAD: begin
        // the CRC follows the nibble currently on the wire; PAD is entered only after the last byte
        crc_d = crc_nib;
        hi_d = !hi_q;
        if (hi_q) begin
          bc_d = bc_inc;
          cnt_d = '0;
          if (last_q) state_d = (int'(bc_inc) < MIN_PAYLOAD) ? S_PAD : TAIL;
          else if (s_valid) begin
            byte_d = s_data;
            last_d = s_last;
          end else begin
            state_d = S_DRAIN;
            underrun_d = 1'b1;
          end
        end
      end
      S_FCS: if (cnt_q == 6'd7) begin
        state_d = S_IFG;
        cnt_d = '0;
      end
      S_IFG: if (cnt_q == IFG_END) state_d = S_IDLE;
      S_DRAIN: begin
        cnt_d = '0;
        if (s_valid && s_last) state_d = S_IFG;
      end
      default: state_d = S_IDLE;
    endcase
    crc_x = ~crc_d;
    tx_en_d = state_d inside {S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS};
    tx_d_d = state_d == S_PREAMBLE ? PREAMBLE_NIB :
             state_d == S_SFD ? (cnt_d[0] ? SFD_NIB : PREAMBLE_NIB) :
             state_d == S_DATA ? (hi_d ? byte_d[7:4] : byte_d[3:0]) :
             state_d == S_FCS ? crc_x[{cnt_d[2:0], 2'b00} +: 4] : 4'h0;
    s_ready_d = state_d == S_IDLE || state_d == S_DRAIN || (state_d == S_DATA && hi_d && !last_d);
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      hi_q <= 1'b0;
      last_q <= 1'b0;
      byte_q <= '0;
      bc_q <= '0;
      crc_q <= '0;
      s_ready_q <= 1'b0;
      tx_en_q <= 1'b0;
      tx_d_q <= '0;
      underrun_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      last_q <= last_d;
      byte_q <= byte_d;
      bc_q <= bc_d;
      crc_q <= crc_d;
      s_ready_q <= s_ready_d;
      tx_en_q <= tx_en_d;
      tx_d_q <= tx_d_d;
      underrun_q <= underrun_d;
      busy_q <= busy_d;
    end
  end
  assign s_ready = s_ready_q;
  assign tx_en = tx_en_q;
  assign tx_d = tx_d_q;
  assign underrun = underrun_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_rgmii_nibble_tx.sv
// tb_rgmii_nibble_tx: table-driven and randomized frames checked against a byte-level frame model
module tb_rgmii_nibble_tx;
  localparam int PRE_N = 14;
  localparam int IFG_N = 24;
  typedef struct {
    int sel;
    int len;
    logic [7:0] first;
    int stall_at;
    int exp_len;
    int exp_und;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [7:0] s_data[2];
  logic s_valid[2], s_last[2], s_ready[2], tx_en[2], underrun[2], busy[2];
  logic [3:0] tx_d[2];
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] capq[2][$];
  int en_run[2], last_len[2], frames[2], und_cnt[2], since_fall[2], rdy_gap[2], gap[2], rdy_fr[2], bad_idle[2];
  logic prev_en[2], pend[2];
  always #5 clk = ~clk;
  rgmii_nibble_tx dut_a (
    .clk(clk), .reset_n(reset_n), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .tx_en(tx_en[0]), .tx_d(tx_d[0]), .underrun(underrun[0]), .busy(busy[0])
  );
  rgmii_nibble_tx #(.MIN_PAYLOAD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .tx_en(tx_en[1]), .tx_d(tx_d[1]), .underrun(underrun[1]), .busy(busy[1])
  );
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  task automatic model(input logic [7:0] b[$], input int minp, output logic [3:0] e[$]);
    logic [7:0] p[$];
    logic [31:0] c;
    p = b;
    c = 32'hFFFFFFFF;
    e = {};
    while (p.size() < minp) p.push_back(8'h00);
    repeat (PRE_N) e.push_back(4'h5);
    e.push_back(4'h5);
    e.push_back(4'hD);
    foreach (p[k]) begin
      e.push_back(p[k][3:0]);
      e.push_back(p[k][7:4]);
      c = crc_byte(c, p[k]);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) e.push_back(c[4*k +: 4]);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_en[i]) begin
        if (!prev_en[i]) begin
          gap[i] = since_fall[i];
          rdy_fr[i] = 0;
        end
        capq[i].push_back(tx_d[i]);
        en_run[i]++;
        if (s_ready[i]) rdy_fr[i]++;
      end else begin
        if (prev_en[i]) begin
          last_len[i] = en_run[i];
          frames[i]++;
          en_run[i] = 0;
          since_fall[i] = 0;
          pend[i] = 1'b1;
        end
        if (pend[i] && s_ready[i]) begin
          rdy_gap[i] = since_fall[i];
          pend[i] = 1'b0;
        end
        since_fall[i]++;
        if (tx_d[i] != 4'h0) bad_idle[i]++;
      end
      if (underrun[i]) und_cnt[i]++;
      prev_en[i] = tx_en[i];
    end
  end
  task automatic run_frame(input int sel, input logic [7:0] b[$], input int stall_at, input int exp_len,
                           input int exp_und);
    logic [3:0] e[$];
    int f0, u0, idx, stall, cyc, post, mis, n;
    n = b.size();
    capq[sel].delete();
    f0 = frames[sel];
    u0 = und_cnt[sel];
    idx = 0;
    stall = 0;
    cyc = 0;
    while (idx < n && cyc < 4000) begin
      tick();
      cyc++;
      if (stall_at >= 0 && idx == stall_at && stall < 4) begin
        s_valid[sel] = 1'b0;
        stall++;
      end else begin
        s_valid[sel] = 1'b1;
        s_data[sel] = b[idx];
        s_last[sel] = (idx == n - 1);
        if (s_ready[sel]) idx++;
      end
    end
    tick();
    s_valid[sel] = 1'b0;
    s_last[sel] = 1'b0;
    check("bytes accepted", idx, n);
    post = 1;
    cyc = 0;
    while ((frames[sel] == f0 || busy[sel]) && cyc < 4000) begin
      tick();
      post++;
      cyc++;
    end
    check("returned to idle", busy[sel], 0);
    check("tx_en length", last_len[sel], exp_len);
    check("underrun pulses", und_cnt[sel] - u0, exp_und);
    model(b, sel == 0 ? 60 : 0, e);
    if (stall_at >= 0) while (e.size() > PRE_N + 2 + 2 * stall_at) void'(e.pop_back());
    check("nibble count", capq[sel].size(), e.size());
    mis = 0;
    for (int k = 0; k < e.size() && k < capq[sel].size(); k++) if (capq[sel][k] != e[k]) mis++;
    check("nibble content", mis, 0);
    if (stall_at < 0) begin
      check("ready cycles in frame", rdy_fr[sel], n - 1);
      check("ifg before ready", rdy_gap[sel], IFG_N);
    end else check("drain+ifg to idle", post, IFG_N + 1);
  endtask
  initial begin
    vec_t vt[6];
    logic [7:0] b[$];
    logic [31:0] fcs;
    int f0, cyc, sel, len;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0;
      s_last[i] = 1'b0;
      s_data[i] = 8'h00;
      prev_en[i] = 1'b0;
      pend[i] = 1'b0;
    end
    vt[0] = '{1, 9, 8'h31, -1, 42, 0};
    vt[1] = '{0, 1, 8'hA5, -1, 144, 0};
    vt[2] = '{0, 60, 8'h10, -1, 144, 0};
    vt[3] = '{0, 61, 8'h80, -1, 146, 0};
    vt[4] = '{1, 1, 8'hF0, -1, 26, 0};
    vt[5] = '{0, 10, 8'h40, 3, 22, 1};
    #1 reset_n = 1'b0;
    s_valid[0] = 1'b1;
    s_last[0] = 1'b1;
    tick();
    tick();
    check("reset tx_en", tx_en[0], 0);
    check("reset tx_d", tx_d[0], 0);
    check("reset s_ready", s_ready[0], 0);
    check("reset underrun", underrun[0], 0);
    check("reset busy", busy[0], 0);
    check("reset busy b", busy[1], 0);
    s_valid[0] = 1'b0;
    s_last[0] = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      b = {};
      for (int k = 0; k < vt[i].len; k++) b.push_back(vt[i].first + 8'(k));
      run_frame(vt[i].sel, b, vt[i].stall_at, vt[i].exp_len, vt[i].exp_und);
      if (vt[i].sel == 1 && vt[i].first == 8'h31 && capq[1].size() == 42) begin
        fcs = '0;
        for (int k = 0; k < 8; k++) fcs[4*k +: 4] = capq[1][34 + k];
        check("check value 123456789", fcs, 32'hCBF43926);
      end
    end
    f0 = frames[0];
    s_valid[0] = 1'b1;
    s_last[0] = 1'b1;
    s_data[0] = 8'h5A;
    cyc = 0;
    while (frames[0] < f0 + 2 && cyc < 2000) begin
      tick();
      cyc++;
    end
    s_valid[0] = 1'b0;
    s_last[0] = 1'b0;
    check("b2b frames", frames[0] - f0, 2);
    check("b2b fall to rise", gap[0], IFG_N + 1);
    check("b2b ifg before ready", rdy_gap[0], IFG_N);
    check("b2b length", last_len[0], 144);
    cyc = 0;
    while (busy[0] && cyc < 200) begin
      tick();
      cyc++;
    end
    s_valid[0] = 1'b1;
    s_last[0] = 1'b1;
    s_data[0] = 8'hC3;
    tick();
    s_valid[0] = 1'b0;
    s_last[0] = 1'b0;
    cyc = 0;
    while (en_run[0] < 139 && cyc < 400) begin
      tick();
      cyc++;
    end
    check("reached fcs", en_run[0], 139);
    #2 reset_n = 1'b0;
    #1;
    check("async reset tx_en", tx_en[0], 0);
    check("async reset tx_d", tx_d[0], 0);
    check("async reset s_ready", s_ready[0], 0);
    s_valid[0] = 1'b1;
    s_last[0] = 1'b1;
    tick();
    tick();
    check("reset beats s_valid", busy[0], 0);
    s_valid[0] = 1'b0;
    s_last[0] = 1'b0;
    reset_n = 1'b1;
    tick();
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame(0, b, -1, 144, 0);
    for (int r = 0; r < 8; r++) begin
      sel = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 70));
      b = {};
      for (int k = 0; k < len; k++) b.push_back(8'($urandom));
      repeat ($urandom_range(0, 6)) tick();
      run_frame(sel, b, -1, PRE_N + 2 + 2 * ((sel == 0 && len < 60) ? 60 : len) + 8, 0);
    end
    check("idle tx_d zero a", bad_idle[0], 0);
    check("idle tx_d zero b", bad_idle[1], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
